// File: rtl/accum_bus_pkg.sv
// Shared types and frame layout helpers for the accumulate-and-send bus master.
package accum_bus_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_ACCUM,
    S_SEND
  } state_e;

  localparam logic [7:0]  TAG_DEFAULT = 8'hAC;
  localparam int unsigned TAG_W       = 8;
  localparam int unsigned SUM_LSB     = 0;

  // Frame layout, MSB first: {tag, zero pad, cnt, sum}.
  function automatic int unsigned cnt_lsb(input int unsigned sum_w);
    return SUM_LSB + sum_w;
  endfunction

  function automatic int unsigned tag_lsb(input int unsigned bus_w);
    return bus_w - TAG_W;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for the raw button followed by a registered
// rising-edge detector; emits a single-cycle press pulse per clean press.
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;
  logic       press_q, press_d;

  always_comb begin
    sync_d  = {sync_q[0], btn_i};
    prev_d  = sync_q[1];
    press_d = sync_q[1] & ~prev_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/accum_bus_master.sv
// Button-driven multiply-by-repeated-addition engine that ships each result
// as a tagged frame over a valid/ready handshake.
module accum_bus_master
  import accum_bus_pkg::*;
#(
  parameter int unsigned IN_W  = 4,
  parameter int unsigned CNT_W = 7,
  parameter int unsigned SUM_W = 14,
  parameter int unsigned BUS_W = 32,
  parameter logic [7:0]  TAG   = TAG_DEFAULT,
  parameter bit          MODE  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in1,
  input  logic [IN_W-1:0]  in2,
  input  logic             btn,
  input  logic             bus_ready,
  output logic [BUS_W-1:0] dataBus,
  output logic             bus_valid,
  output logic             busy,
  output logic             ovf
);

  localparam int unsigned CNT_LSB = cnt_lsb(SUM_W);
  localparam int unsigned TAG_LSB = tag_lsb(BUS_W);

  state_e             state_q, state_d;
  logic [IN_W-1:0]    a_q, a_d;
  logic [IN_W-1:0]    n_q, n_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic               ovf_q, ovf_d;
  logic [BUS_W-1:0]   frame_q, frame_d;
  logic               valid_q, valid_d;

  logic               press;
  logic [CNT_W-1:0]   n_ext;
  logic [SUM_W:0]     add_res;
  logic [BUS_W-1:0]   frame_new;

  btn_sync_edge u_btn_sync_edge (
    .clk     (clk),
    .rst_n   (rst),
    .btn_i   (btn),
    .press_o (press)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    frame_d = frame_q;
    valid_d = valid_q;

    n_ext   = CNT_W'(n_q);
    // Extra MSB catches the carry-out of the SUM_W-bit add.
    add_res = {1'b0, sum_q} + (SUM_W+1)'(a_q);

    frame_new                        = '0;
    frame_new[TAG_LSB +: TAG_W]      = TAG;
    frame_new[CNT_LSB +: CNT_W]      = cnt_q;
    frame_new[SUM_LSB +: SUM_W]      = sum_q;

    unique case (state_q)
      S_IDLE: begin
        if (press) begin
          a_d     = in1;
          n_d     = in2;
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (press) begin
          cnt_d = '0;
          if (!MODE) begin
            sum_d = '0;
            ovf_d = 1'b0;
          end
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (cnt_q == n_ext) begin
          frame_d = frame_new;
          valid_d = 1'b1;
          state_d = S_SEND;
        end else begin
          sum_d = add_res[SUM_W-1:0];
          cnt_d = cnt_q + CNT_W'(1);
          if (add_res[SUM_W]) begin
            ovf_d = 1'b1;
          end
        end
      end
      S_SEND: begin
        if (valid_q && bus_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      frame_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      frame_q <= frame_d;
      valid_q <= valid_d;
    end
  end

  assign dataBus   = frame_q;
  assign bus_valid = valid_q;
  assign busy      = (state_q == S_ACCUM) || (state_q == S_SEND);
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_accum_bus_master.sv
// Directed bench: three instances (MODE 0, MODE 1, MODE 1 with SUM_W=8)
// sharing clock, reset and operands, each with its own button and ready.
module tb_accum_bus_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in1, in2;
  logic [2:0]  btn, rdy;
  logic [31:0] dbus [3];
  logic [2:0]  valid, busy, ovf;

  int n_checks = 0;
  int n_errors = 0;

  int cyc = 0;
  int vcyc       [3] = '{default: 0};
  int hs         [3] = '{default: 0};
  int changed    [3] = '{default: 0};
  int busy_rise  [3] = '{default: 0};
  int valid_rise [3] = '{default: 0};
  logic [31:0] cap [3] = '{default: '0};
  logic [2:0] busy_p = '0, valid_p = '0;

  int hbase [3];
  int vbase [3];
  int cbase [3];

  always #5 clk = ~clk;

  accum_bus_master u_dut0 (
    .clk(clk), .rst(rst_n), .in1(in1), .in2(in2), .btn(btn[0]), .bus_ready(rdy[0]),
    .dataBus(dbus[0]), .bus_valid(valid[0]), .busy(busy[0]), .ovf(ovf[0])
  );

  accum_bus_master #(.MODE(1'b1)) u_dut1 (
    .clk(clk), .rst(rst_n), .in1(in1), .in2(in2), .btn(btn[1]), .bus_ready(rdy[1]),
    .dataBus(dbus[1]), .bus_valid(valid[1]), .busy(busy[1]), .ovf(ovf[1])
  );

  accum_bus_master #(.MODE(1'b1), .SUM_W(8)) u_dut2 (
    .clk(clk), .rst(rst_n), .in1(in1), .in2(in2), .btn(btn[2]), .bus_ready(rdy[2]),
    .dataBus(dbus[2]), .bus_valid(valid[2]), .busy(busy[2]), .ovf(ovf[2])
  );

  // Observe on the falling edge: ACCUM entry, frame capture, hold and handshakes.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (busy[i] && !busy_p[i]) busy_rise[i] = cyc;
      if (valid[i]) begin
        vcyc[i]++;
        if (!valid_p[i]) begin
          valid_rise[i] = cyc;
          cap[i] = dbus[i];
        end else if (dbus[i] !== cap[i]) begin
          changed[i]++;
        end
        if (rdy[i]) hs[i]++;
      end
      busy_p[i]  = busy[i];
      valid_p[i] = valid[i];
    end
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic press(input logic [2:0] m);
    @(posedge clk); #1;
    btn = btn | m;
    repeat (5) @(posedge clk);
    #1;
    btn = btn & ~m;
    repeat (4) @(posedge clk);
  endtask

  task automatic snap();
    for (int i = 0; i < 3; i++) begin
      hbase[i] = hs[i];
      vbase[i] = vcyc[i];
      cbase[i] = changed[i];
    end
  endtask

  task automatic wait_hs(input logic [2:0] m, input string tag);
    bit done;
    for (int k = 0; k < 200; k++) begin
      done = 1'b1;
      for (int i = 0; i < 3; i++) if (m[i] && hs[i] == hbase[i]) done = 1'b0;
      if (done) break;
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) if (m[i]) check(tag, hs[i] - hbase[i], 1);
  endtask

  task automatic run(input logic [2:0] m, input int a, input int n, input string tag);
    snap();
    in1 = 4'(a);
    in2 = 4'(n);
    press(m);
    press(m);
    wait_hs(m, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int drops;
    rst_n = 1'b0;
    in1 = '0; in2 = '0; btn = '0; rdy = '1;
    #1;
    check("rst_dbus",  dbus[0], 32'h0);
    check("rst_valid", 32'(valid[0]), 32'h0);
    check("rst_busy",  32'(busy[0]), 32'h0);
    check("rst_ovf",   32'(ovf[0]), 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // a=3, n=5
    run(3'b001, 3, 5, "t1_done");
    check("t1_frame",   cap[0], 32'hAC01400F);
    check("t1_vcycles", vcyc[0] - vbase[0], 1);
    check("t1_latency", valid_rise[0] - busy_rise[0], 6);
    check("t1_ovf",     32'(ovf[0]), 32'h0);

    // n=0 boundary
    run(3'b001, 7, 0, "t2_done");
    check("t2_frame",   cap[0], 32'hAC000000);
    check("t2_latency", valid_rise[0] - busy_rise[0], 1);

    // backpressure with a press during SEND
    rdy[0] = 1'b0;
    snap();
    in1 = 4'd2; in2 = 4'd4;
    press(3'b001);
    press(3'b001);
    for (int k = 0; k < 50; k++) begin
      if (valid[0]) break;
      @(negedge clk);
    end
    check("t3_valid_up", 32'(valid[0]), 32'h1);
    drops = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!valid[0]) drops++;
      #1;
      if (k == 1) btn[0] = 1'b1;
      if (k == 6) btn[0] = 1'b0;
    end
    check("t3_drops", drops, 0);
    @(negedge clk); #1 rdy[0] = 1'b1;
    @(posedge clk); #1;
    check("t3_valid_done", 32'(valid[0]), 32'h0);
    check("t3_busy_done",  32'(busy[0]), 32'h0);
    check("t3_frame",      cap[0], 32'hAC010008);
    check("t3_held",       dbus[0], 32'hAC010008);
    check("t3_stable",     changed[0] - cbase[0], 0);
    repeat (4) @(posedge clk);
    run(3'b001, 3, 2, "t3b_done");
    check("t3b_frame", cap[0], 32'hAC008006);

    // MODE 1 accumulate, SUM_W=14 and SUM_W=8
    run(3'b110, 15, 15, "t4a_done");
    check("t4a_frame14", cap[1], 32'hAC03C0E1);
    check("t4a_frame8",  cap[2], 32'hAC000FE1);
    check("t4a_ovf8",    32'(ovf[2]), 32'h0);
    run(3'b110, 15, 15, "t4b_done");
    check("t4b_frame14", cap[1], 32'hAC03C1C2);
    check("t4b_frame8",  cap[2], 32'hAC000FC2);
    check("t4b_ovf14",   32'(ovf[1]), 32'h0);
    check("t4b_ovf8",    32'(ovf[2]), 32'h1);

    // async reset mid-ACCUM at cnt=4
    in1 = 4'd5; in2 = 4'd10;
    press(3'b001);
    @(posedge clk); #1 btn[0] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy[0]) break;
    end
    check("t5_busy_pre", 32'(busy[0]), 32'h1);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t5_busy",   32'(busy[0]), 32'h0);
    check("t5_valid",  32'(valid[0]), 32'h0);
    check("t5_dbus0",  dbus[0], 32'h0);
    check("t5_dbus1",  dbus[1], 32'h0);
    check("t5_ovf0",   32'(ovf[0]), 32'h0);
    check("t5_ovf2",   32'(ovf[2]), 32'h0);
    btn[0] = 1'b0;
    #10 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    run(3'b001, 1, 3, "t5b_done");
    check("t5b_frame", cap[0], 32'hAC00C003);

    // long hold plus sub-cycle glitches: one transition only
    snap();
    in1 = 4'd1; in2 = 4'd2;
    @(posedge clk); #1 btn[0] = 1'b1;
    repeat (50) @(posedge clk);
    #1 btn[0] = 1'b0;
    repeat (5) begin
      @(negedge clk);
      #1 btn[0] = 1'b1;
      #2 btn[0] = 1'b0;
    end
    repeat (5) @(posedge clk);
    #1;
    check("t6_armed_busy", 32'(busy[0]), 32'h0);
    check("t6_armed_hs",   hs[0] - hbase[0], 0);
    press(3'b001);
    wait_hs(3'b001, "t6_done");
    check("t6_frame", cap[0], 32'hAC008002);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
